// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - decode-to-execute operand stage with MEM/WB bypass and load-use interlock

// Per-source operand select: x0 is hard zero, then MEM bypass, then WB bypass, then regfile.
module id_ex_fwd_sel #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_wen,
  input  logic [XLEN-1:0] mem_data,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_wen,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] val
);

  // MEM holds the younger result, so it must win over WB for the same index.
  always_comb begin
    val = rf_data;
    if (rs == '0) begin
      val = '0;
    end else if (mem_reg_wen && (mem_rd == rs)) begin
      val = mem_data;
    end else if (wb_reg_wen && (wb_rd == rs)) begin
      val = wb_data;
    end
  end

endmodule

module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_wen,
  input  logic            id_is_load,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_wen,
  input  logic [XLEN-1:0] mem_data,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_wen,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_wen,
  output logic            ex_is_load
);

  logic [XLEN-1:0] fwd_rs1_val;
  logic [XLEN-1:0] fwd_rs2_val;
  logic            load_in_ex;
  logic            rs1_dep;
  logic            rs2_dep;
  logic            hazard;

  id_ex_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs          (id_rs1),
    .rf_data     (rf_data1),
    .mem_rd      (mem_rd),
    .mem_reg_wen (mem_reg_wen),
    .mem_data    (mem_data),
    .wb_rd       (wb_rd),
    .wb_reg_wen  (wb_reg_wen),
    .wb_data     (wb_data),
    .val         (fwd_rs1_val)
  );

  id_ex_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs          (id_rs2),
    .rf_data     (rf_data2),
    .mem_rd      (mem_rd),
    .mem_reg_wen (mem_reg_wen),
    .mem_data    (mem_data),
    .wb_rd       (wb_rd),
    .wb_reg_wen  (wb_reg_wen),
    .wb_data     (wb_data),
    .val         (fwd_rs2_val)
  );

  // A load sitting in EX has no data yet; any dependent consumer must wait one cycle
  // until the load reaches MEM and the value arrives on mem_data.
  always_comb begin
    load_in_ex = ex_valid && ex_is_load && ex_reg_wen && (ex_rd != '0);
    rs1_dep    = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_dep    = id_use_rs2 && (id_rs2 == ex_rd);
    hazard     = load_in_ex && id_valid && (rs1_dep || rs2_dep);
    id_ready   = !ex_stall && !hazard;
  end

  // Output bundle: reset, flush, stall-hold, bubble or capture, in that priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_reg_wen <= 1'b0;
      ex_is_load <= 1'b0;
      ex_pc      <= '0;
      ex_imm     <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_rd      <= '0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_reg_wen <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (ex_stall) begin
      ex_valid   <= ex_valid;
    end else if (hazard || !id_valid) begin
      // Bubble: control cleared so it can never look like a producer; data left as-is.
      ex_valid   <= 1'b0;
      ex_reg_wen <= 1'b0;
      ex_is_load <= 1'b0;
    end else begin
      ex_valid   <= 1'b1;
      ex_reg_wen <= id_reg_wen;
      ex_is_load <= id_is_load;
      ex_pc      <= id_pc;
      ex_imm     <= id_imm;
      ex_rs1_val <= fwd_rs1_val;
      ex_rs2_val <= fwd_rs2_val;
      ex_rd      <= id_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed scoreboard bench for id_ex_operand_stage

module tb_id_ex_operand_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_wen;
  logic        id_is_load;
  logic [31:0] rf_data1;
  logic [31:0] rf_data2;
  logic [4:0]  mem_rd;
  logic        mem_reg_wen;
  logic [31:0] mem_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_wen;
  logic [31:0] wb_data;
  logic        ex_stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [4:0]  ex_rd;
  logic        ex_reg_wen;
  logic        ex_is_load;

  id_ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_imm      (id_imm),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_reg_wen  (id_reg_wen),
    .id_is_load  (id_is_load),
    .rf_data1    (rf_data1),
    .rf_data2    (rf_data2),
    .mem_rd      (mem_rd),
    .mem_reg_wen (mem_reg_wen),
    .mem_data    (mem_data),
    .wb_rd       (wb_rd),
    .wb_reg_wen  (wb_reg_wen),
    .wb_data     (wb_data),
    .ex_stall    (ex_stall),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_rs1_val  (ex_rs1_val),
    .ex_rs2_val  (ex_rs2_val),
    .ex_rd       (ex_rd),
    .ex_reg_wen  (ex_reg_wen),
    .ex_is_load  (ex_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        full;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  rd;
    logic        wen;
    logic        ld;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_vec;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_cap(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [4:0] rd, input logic wen, input logic ld);
    exp_t e;
    e = '{valid: 1'b1, full: 1'b1, pc: pc, imm: imm, v1: v1, v2: v2, rd: rd, wen: wen, ld: ld};
    last = e;
    q.push_back(e);
  endtask

  task automatic exp_bub();
    exp_t e;
    e = '0;
    q.push_back(e);
  endtask

  task automatic exp_zero();
    exp_t e;
    e = '0;
    e.full = 1'b1;
    q.push_back(e);
  endtask

  task automatic exp_hold();
    q.push_back(last);
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wen, input logic ld);
    id_valid = v; id_pc = pc; id_imm = imm;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_wen = wen; id_is_load = ld;
  endtask

  task automatic set_fwd(input logic [4:0] mrd, input logic mwen, input logic [31:0] mdata,
                         input logic [4:0] wrd, input logic wwen, input logic [31:0] wdata);
    mem_rd = mrd; mem_reg_wen = mwen; mem_data = mdata;
    wb_rd = wrd; wb_reg_wen = wwen; wb_data = wdata;
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    #1;
    chk(tag, {31'b0, id_ready}, {31'b0, exp});
  endtask

  // One clock: let the edge happen, then compare the registered bundle with the oldest expectation.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_vec++;
      n_fail++;
      $error("FAIL %s.sb_empty: observed empty queue expected entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".valid"}, {31'b0, ex_valid},   {31'b0, e.valid});
      chk({tag, ".wen"},   {31'b0, ex_reg_wen}, {31'b0, e.wen});
      chk({tag, ".load"},  {31'b0, ex_is_load}, {31'b0, e.ld});
      if (e.full) begin
        chk({tag, ".pc"},  ex_pc,      e.pc);
        chk({tag, ".imm"}, ex_imm,     e.imm);
        chk({tag, ".rs1"}, ex_rs1_val, e.v1);
        chk({tag, ".rs2"}, ex_rs2_val, e.v2);
        chk({tag, ".rd"},  {27'b0, ex_rd}, {27'b0, e.rd});
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    last = '0;
    rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    rf_data1 = 32'hA1; rf_data2 = 32'hA2;
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    offer(1'b1, 32'h100, 32'h4, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);

    // Reset dominates a valid offered bundle for two edges
    exp_zero(); tick("rst0");
    exp_zero(); tick("rst1");
    rst = 1'b0;
    chk_ready("rst_ready", 1'b1);
    exp_cap(32'h100, 32'h4, 32'hA1, 32'hA2, 5'd3, 1'b1, 1'b0); tick("first");

    // Forward priority on rs1: MEM > WB > regfile, x0 never forwarded
    rf_data1 = 32'h11; rf_data2 = 32'h55;
    offer(1'b1, 32'h104, 32'h8, 5'd5, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    set_fwd(5'd5, 1'b1, 32'h33, 5'd5, 1'b1, 32'h22);
    exp_cap(32'h104, 32'h8, 32'h33, 32'h0, 5'd4, 1'b1, 1'b0); tick("fwd_mem");
    set_fwd(5'd5, 1'b0, 32'h33, 5'd5, 1'b1, 32'h22);
    exp_cap(32'h104, 32'h8, 32'h22, 32'h0, 5'd4, 1'b1, 1'b0); tick("fwd_wb");
    set_fwd(5'd5, 1'b0, 32'h33, 5'd5, 1'b0, 32'h22);
    exp_cap(32'h104, 32'h8, 32'h11, 32'h0, 5'd4, 1'b1, 1'b0); tick("fwd_rf");
    offer(1'b1, 32'h108, 32'h0, 5'd0, 1'b1, 5'd6, 1'b1, 5'd4, 1'b1, 1'b0);
    set_fwd(5'd0, 1'b1, 32'h44, 5'd6, 1'b1, 32'h66);
    exp_cap(32'h108, 32'h0, 32'h0, 32'h66, 5'd4, 1'b1, 1'b0); tick("fwd_x0");

    // Idle cycle produces a bubble
    offer(1'b0, 32'h10C, 32'h0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    exp_bub(); tick("idle");

    // Load-use: load x7, consumer on rs2 stalls one cycle, then takes mem_data
    rf_data1 = 32'h1000; rf_data2 = 32'hDEAD;
    offer(1'b1, 32'h200, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    exp_cap(32'h200, 32'h0, 32'h1000, 32'h0, 5'd7, 1'b1, 1'b1); tick("ld");
    offer(1'b1, 32'h204, 32'h0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    chk_ready("lu_ready0", 1'b0);
    exp_bub(); tick("lu_bubble");
    set_fwd(5'd7, 1'b1, 32'hCAFE, 5'd0, 1'b0, 32'h0);
    chk_ready("lu_ready1", 1'b1);
    exp_cap(32'h204, 32'h0, 32'h0, 32'hCAFE, 5'd8, 1'b1, 1'b0); tick("lu_use");

    // Load x7 followed by a bundle naming x7 in an unused field: no stall
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    rf_data2 = 32'h77;
    offer(1'b1, 32'h208, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    exp_cap(32'h208, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1); tick("ld2");
    offer(1'b1, 32'h20C, 32'h0, 5'd0, 1'b0, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0);
    chk_ready("nouse_ready", 1'b1);
    exp_cap(32'h20C, 32'h0, 32'h0, 32'h77, 5'd8, 1'b1, 1'b0); tick("nouse");

    // Load to x0 never interlocks
    offer(1'b1, 32'h210, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    exp_cap(32'h210, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1); tick("ld_x0");
    offer(1'b1, 32'h214, 32'h0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    chk_ready("ldx0_ready", 1'b1);
    exp_cap(32'h214, 32'h0, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0); tick("ldx0_use");

    // Back-to-back ALU chain fed by MEM/WB bypass
    offer(1'b1, 32'h300, 32'h5, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    chk_ready("chain0_ready", 1'b1);
    exp_cap(32'h300, 32'h5, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0); tick("addi_x1");
    offer(1'b1, 32'h304, 32'h0, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
    set_fwd(5'd1, 1'b1, 32'h5, 5'd0, 1'b0, 32'h0);
    chk_ready("chain1_ready", 1'b1);
    exp_cap(32'h304, 32'h0, 32'h5, 32'h5, 5'd2, 1'b1, 1'b0); tick("add_x2");
    offer(1'b1, 32'h308, 32'h0, 5'd2, 1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0);
    set_fwd(5'd2, 1'b1, 32'hA, 5'd1, 1'b1, 32'h5);
    chk_ready("chain2_ready", 1'b1);
    exp_cap(32'h308, 32'h0, 32'hA, 32'h5, 5'd3, 1'b1, 1'b0); tick("add_x3");

    // ex_stall holds the bundle for 3 cycles while a new one waits
    set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    rf_data1 = 32'h123; rf_data2 = 32'h456;
    offer(1'b1, 32'h400, 32'h9, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_ready("stall_ready", 1'b0);
      exp_hold(); tick("stall_hold");
    end
    ex_stall = 1'b0;
    chk_ready("unstall_ready", 1'b1);
    exp_cap(32'h400, 32'h9, 32'h123, 32'h456, 5'd6, 1'b1, 1'b0); tick("unstall");

    // Flush beats stall and hazard together; offered bundle dropped
    offer(1'b1, 32'h500, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    exp_cap(32'h500, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1); tick("ld_x9");
    offer(1'b1, 32'h504, 32'h0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    ex_stall = 1'b1; flush = 1'b1;
    chk_ready("flush_ready", 1'b0);
    exp_bub(); tick("flush");
    ex_stall = 1'b0; flush = 1'b0;
    offer(1'b1, 32'h508, 32'h0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    set_fwd(5'd9, 1'b1, 32'h99, 5'd0, 1'b0, 32'h0);
    chk_ready("post_flush_ready", 1'b1);
    exp_cap(32'h508, 32'h0, 32'h99, 32'h0, 5'd11, 1'b1, 1'b0); tick("post_flush");

    n_vec++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover: observed %0d expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage, directly downstream of the 32x32 register file read ports.
- Takes decoded fields plus raw regfile read data and resolves RAW hazards by bypassing from MEM and WB.
- Detects load-use hazards, inserts bubbles and stalls decode.
- Registers a clean operand bundle (rs1_val/rs2_val, control) for the execute stage.

Parameters:
XLEN, 32, datapath and operand width
RA_W, 5, register address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  decode holds a valid instruction
id_ready  out  1  stage accepts id bundle this cycle (combinational)
id_pc  in  XLEN  instruction PC
id_imm  in  XLEN  decoded immediate
id_rs1  in  RA_W  source 1 index (also drives regfile rs1)
id_rs2  in  RA_W  source 2 index (also drives regfile rs2)
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  RA_W  destination index
id_reg_wen  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
rf_data1  in  XLEN  regfile read data for id_rs1
rf_data2  in  XLEN  regfile read data for id_rs2
mem_rd, mem_reg_wen, mem_data  in  RA_W/1/XLEN  MEM-stage writeback candidate (final value)
wb_rd, wb_reg_wen, wb_data  in  RA_W/1/XLEN  WB-stage write, same cycle as regfile write
ex_stall  in  1  execute cannot accept; hold output bundle
flush  in  1  squash bundle in this stage and the one being offered
ex_valid  out  1  output bundle valid
ex_pc, ex_imm, ex_rs1_val, ex_rs2_val  out  XLEN  registered bundle
ex_rd  out  RA_W  registered destination
ex_reg_wen, ex_is_load  out  1  registered control

Behaviour:
- Reset (rst=1 at edge):
  - ex_valid=0, ex_reg_wen=0, ex_is_load=0.
  - All data outputs 0.
  - Reset dominates every other input.
- Operand select, per source s (combinational, rs = id_rs1/id_rs2):
  - rs==0 -> 0.
  - Else if mem_reg_wen && mem_rd==rs -> mem_data.
  - Else if wb_reg_wen && wb_rd==rs -> wb_data.
  - Else rf_data.
  - MEM beats WB. x0 is never forwarded even if rd==0 and wen=1.
- Load-use hazard:
  - Condition: ex_valid && ex_is_load && ex_reg_wen && ex_rd!=0 && id_valid && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - Unused source fields never cause a hazard.
- Handshake: id_ready = !ex_stall && !hazard. Decode holds its bundle while id_ready=0.
- Edge priority, highest first:
  1. rst.
  2. flush: ex_valid<=0, ex_reg_wen<=0, ex_is_load<=0. Offered id bundle is dropped; decode treats it as consumed.
  3. ex_stall: all ex_* hold, including ex_valid.
  4. hazard: bubble. ex_valid<=0, ex_reg_wen<=0, ex_is_load<=0; data fields don't care.
  5. id_valid: capture bundle with forwarded operands, ex_valid<=1.
  6. Otherwise: bubble, as in case 4.
- Latency: one cycle, id accept to ex_* valid.
- Load-use stall length: one cycle. The next cycle ex holds a bubble, the load is in MEM, and the operand comes via mem_data.
- Invalid bundles (bubbles) always have ex_reg_wen=0, so they never trigger a hazard.
- Throughput: one instruction per cycle when there are no stalls.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 -> ex_valid=0 and all ex_* =0 during and one cycle after; first bundle appears the cycle after rst falls.
- Forward priority: id_rs1=5 use_rs1=1, rf_data1=0x11, wb(rd=5,wen=1,0x22), mem(rd=5,wen=1,0x33) -> ex_rs1_val=0x33.
  - Drop mem_wen -> 0x22.
  - Drop both -> 0x11.
  - id_rs1=0 with mem_rd=0, mem_wen=1 -> ex_rs1_val=0.
- Load-use: load x7 accepted, next id uses rs2=7 -> id_ready=0 one cycle and ex_valid=0 bubble. Following cycle (mem_rd=7, mem_data=0xCAFE) -> ex_rs2_val=0xCAFE, ex_valid=1.
  - Same with use_rs2=0 -> no stall.
- ex_stall: hold 3 cycles with a new id bundle offered -> ex_* unchanged, id_ready=0. Release -> new bundle captured next edge.
- Flush with ex_stall=1 and hazard=1 simultaneously -> ex_valid=0 next cycle; offered id bundle dropped; then normal accept.
- Back-to-back ALU chain: addi x1; add x2,x1,x1; add x3,x2,x1 with matching mem/wb driving -> no stalls, operands correct every cycle.
